// File: rtl/pll_seq_pkg.sv
// ============================================================================
// pll_seq_pkg : shared types and helpers for the PLL reset sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pll_seq_pkg;

   typedef enum logic [1:0] {
      S_PLLRST   = 2'd0,
      S_WAITLOCK = 2'd1,
      S_STABLE   = 2'd2,
      S_RUN      = 2'd3
   } pll_state_e;

   localparam int unsigned RETRY_W = 4;

   // Smallest counter width able to hold (largest cycle limit - 1).
   function automatic int unsigned pll_min_cnt_w(input int unsigned rst_cyc,
                                                 input int unsigned stable_cyc,
                                                 input int unsigned timeout_cyc,
                                                 input int unsigned glitch_cyc);
      int unsigned m;
      m = rst_cyc;
      if (stable_cyc  > m) m = stable_cyc;
      if (timeout_cyc > m) m = timeout_cyc;
      if (glitch_cyc  > m) m = glitch_cyc;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] v);
      return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pll_sync2.sv
// ============================================================================
// pll_sync2 : generic two-flop single-bit synchronizer, async reset to 0
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_sync2 (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// ============================================================================
// pll_reset_seq : PLL reset pulse / lock qualification / system reset release
// Optional lock-loss glitch filter: define PLLSEQ_GLITCH_FILTER_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYC      = 16,
   parameter int unsigned LOCK_STABLE_CYC  = 1000,
   parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
   parameter int unsigned CNT_W            = 16,
   parameter int unsigned GLITCH_CYC       = 4
) (
   input  logic               clkin_i,
   input  logic               rst_ni,
   input  logic               locked_i,
   output logic               pll_rst_o,
   output logic               sys_rst_n_o,
   output logic               lock_lost_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);

   if (CNT_W < pll_min_cnt_w(PLL_RST_CYC, LOCK_STABLE_CYC,
                             LOCK_TIMEOUT_CYC, GLITCH_CYC)) begin : g_cnt_w_chk
      $error("pll_reset_seq: CNT_W too small for the configured cycle limits");
   end

   logic               locked_s;
   pll_state_e         state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               pll_rst_q;
   logic               sys_rst_n_q;
   logic               lock_lost_q;
   logic [RETRY_W-1:0] retry_q;

   pll_sync2 u_lock_sync (
      .clk_i  (clkin_i),
      .rst_ni (rst_ni),
      .d_i    (locked_i),
      .q_o    (locked_s)
   );

   always_ff @(posedge clkin_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_PLLRST;
         cnt_q       <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         lock_lost_q <= 1'b0;
         retry_q     <= '0;
      end else begin
         lock_lost_q <= 1'b0;
         cnt_q       <= cnt_q + 1'b1;
         case (state_q)
            S_PLLRST: begin
               pll_rst_q   <= 1'b1;
               sys_rst_n_q <= 1'b0;
               if (cnt_q == RST_LAST) begin
                  state_q   <= S_WAITLOCK;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b0;
               end
            end
            S_WAITLOCK: begin
               pll_rst_q   <= 1'b0;
               sys_rst_n_q <= 1'b0;
               if (locked_s) begin
                  state_q <= S_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q   <= S_PLLRST;
                  cnt_q     <= '0;
                  pll_rst_q <= 1'b1;
                  retry_q   <= retry_sat_inc(retry_q);
               end
            end
            S_STABLE: begin
               pll_rst_q   <= 1'b0;
               sys_rst_n_q <= 1'b0;
               if (!locked_s) begin
                  state_q <= S_WAITLOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == STABLE_LAST) begin
                  state_q     <= S_RUN;
                  cnt_q       <= '0;
                  sys_rst_n_q <= 1'b1;
               end
            end
            S_RUN: begin
               pll_rst_q   <= 1'b0;
               sys_rst_n_q <= 1'b1;
`ifdef PLLSEQ_GLITCH_FILTER_EN
               // cnt_q tracks the current run of low locked_s samples.
               if (locked_s) begin
                  cnt_q <= '0;
               end else if (cnt_q == CNT_W'(GLITCH_CYC - 1)) begin
                  state_q     <= S_PLLRST;
                  cnt_q       <= '0;
                  pll_rst_q   <= 1'b1;
                  sys_rst_n_q <= 1'b0;
                  lock_lost_q <= 1'b1;
                  retry_q     <= retry_sat_inc(retry_q);
               end
`else
               // RUN has no terminal count; hold the counter so it cannot wrap.
               cnt_q <= '0;
               if (!locked_s) begin
                  state_q     <= S_PLLRST;
                  pll_rst_q   <= 1'b1;
                  sys_rst_n_q <= 1'b0;
                  lock_lost_q <= 1'b1;
                  retry_q     <= retry_sat_inc(retry_q);
               end
`endif
            end
            default: begin
               state_q     <= S_PLLRST;
               cnt_q       <= '0;
               pll_rst_q   <= 1'b1;
               sys_rst_n_q <= 1'b0;
            end
         endcase
      end
   end

   assign pll_rst_o   = pll_rst_q;
   assign sys_rst_n_o = sys_rst_n_q;
   assign lock_lost_o = lock_lost_q;
   assign retry_cnt_o = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// ============================================================================
// tb_pll_reset_seq : directed self-checking bench for pll_reset_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pll_reset_seq;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       pll_rst;
   logic       sys_rst_n;
   logic       lock_lost;
   logic [3:0] retry_cnt;

   int n_chk  = 0;
   int n_err  = 0;
   int ll_cnt = 0;
   int sys_hi = 0;

   pll_reset_seq #(
      .PLL_RST_CYC      (4),
      .LOCK_STABLE_CYC  (8),
      .LOCK_TIMEOUT_CYC (32),
      .CNT_W            (16),
      .GLITCH_CYC       (4)
   ) dut (
      .clkin_i     (clk),
      .rst_ni      (rst_n),
      .locked_i    (locked),
      .pll_rst_o   (pll_rst),
      .sys_rst_n_o (sys_rst_n),
      .lock_lost_o (lock_lost),
      .retry_cnt_o (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance n rising edges, sampling 1 time unit after each edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (lock_lost) ll_cnt++;
         if (sys_rst_n) sys_hi++;
      end
   endtask

   // Release reset just after edge 0 and follow the nominal bring-up to edge 13.
   task automatic bringup(input string tag);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(3);
      check({tag, "_pllrst_e3"}, pll_rst, 1'b1);
      step(1);
      check({tag, "_pllrst_e4"}, pll_rst, 1'b0);
      step(8);
      check({tag, "_sysrst_e12"}, sys_rst_n, 1'b0);
      step(1);
      check({tag, "_sysrst_e13"}, sys_rst_n, 1'b1);
   endtask

   initial begin
      int exp_r;
      rst_n  = 1'b0;
      locked = 1'b1;
      step(2);
      check("rst_pll_rst", pll_rst, 1'b1);
      check("rst_sys_rst_n", sys_rst_n, 1'b0);
      check("rst_lock_lost", lock_lost, 1'b0);
      check("rst_retry", retry_cnt, 4'd0);

      // Nominal bring-up with locked held high.
      bringup("nom");
      check("nom_retry", retry_cnt, 4'd0);

`ifndef PLLSEQ_GLITCH_FILTER_EN
      // One-cycle dropout while running (now just after edge 13).
      ll_cnt = 0;
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      check("loss_e14_sys", sys_rst_n, 1'b1);
      step(1);
      check("loss_e15_sys", sys_rst_n, 1'b1);
      step(1);
      check("loss_e16_sys", sys_rst_n, 1'b0);
      check("loss_e16_pll", pll_rst, 1'b1);
      check("loss_e16_pulse", lock_lost, 1'b1);
      check("loss_e16_retry", retry_cnt, 4'd1);
      step(1);
      check("loss_e17_pulse", lock_lost, 1'b0);
      check("loss_pulse_count", ll_cnt, 1);
      // Re-run: PLLRST 16..19, WAITLOCK at 20, STABLE from 21.
      step(3);
      check("loss_e20_pll", pll_rst, 1'b0);
      step(3);
      check("loss_e23_sys", sys_rst_n, 1'b0);
`else
      // Three-cycle dropout must be filtered out.
      ll_cnt = 0;
      locked = 1'b0;
      step(3);
      locked = 1'b1;
      step(8);
      check("glitch3_pulse_count", ll_cnt, 0);
      check("glitch3_sys", sys_rst_n, 1'b1);
      check("glitch3_retry", retry_cnt, 4'd0);
      // Four-cycle dropout from edge N: loss action at edge N+6.
      locked = 1'b0;
      step(4);
      locked = 1'b1;
      step(1);
      check("glitch4_n5_sys", sys_rst_n, 1'b1);
      step(1);
      check("glitch4_n6_sys", sys_rst_n, 1'b0);
      check("glitch4_n6_pulse", lock_lost, 1'b1);
      check("glitch4_n6_retry", retry_cnt, 4'd1);
      step(6);
`endif

      // Asynchronous reset between edges: outputs change without a clock.
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_pll_rst", pll_rst, 1'b1);
      check("arst_sys_rst_n", sys_rst_n, 1'b0);
      check("arst_retry", retry_cnt, 4'd0);
      step(2);
      bringup("rearm");

      // Unstable lock: drop locked for one cycle when the stable count is 5.
      rst_n = 1'b0;
      step(2);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(10);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(10);
      check("unstab_e21_sys", sys_rst_n, 1'b0);
      step(1);
      check("unstab_e22_sys", sys_rst_n, 1'b1);
      check("unstab_retry", retry_cnt, 4'd0);

      // Timeout: no lock at all; 36-cycle retry period, saturating count.
      rst_n  = 1'b0;
      locked = 1'b0;
      step(2);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      sys_hi = 0;
      step(35);
      check("tmo_e35_pll", pll_rst, 1'b0);
      check("tmo_e35_retry", retry_cnt, 4'd0);
      step(1);
      check("tmo_e36_pll", pll_rst, 1'b1);
      check("tmo_e36_retry", retry_cnt, 4'd1);
      step(3);
      check("tmo_e39_pll", pll_rst, 1'b1);
      step(1);
      check("tmo_e40_pll", pll_rst, 1'b0);
      step(32);
      check("tmo_e72_retry", retry_cnt, 4'd2);
      for (int p = 3; p <= 17; p++) begin
         step(36);
         exp_r = (p > 15) ? 15 : p;
         check("tmo_retry_sat", retry_cnt, exp_r);
      end
      check("tmo_sys_never_high", sys_hi, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
